// File: rtl/pipe_pkg.sv
// Shared pipeline control encoding used by pipeline_ctrl and every inter-stage latch.
package pipe_pkg;

    typedef enum logic [1:0] {
        CTR_RUN    = 2'b00,
        CTR_HOLD   = 2'b01,
        CTR_FLUSH  = 2'b10,
        CTR_BUBBLE = 2'b11
    } ctr_t;

    // Modes in which payloads already inside a latch keep flowing downstream.
    function automatic logic ctr_moves(input ctr_t c);
        return (c == CTR_RUN) || (c == CTR_BUBBLE);
    endfunction

endpackage

// File: rtl/latchn_skid.sv
// Two-entry skid FIFO behind the last stage of latchn_hs (used when LATCHN_SKID_BUF_EN is defined).
module latchn_skid #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       fill
);

    logic [WIDTH-1:0] mem0;
    logic [WIDTH-1:0] mem1;
    logic [1:0]       cnt;
    logic             do_push;
    logic             do_pop;

    assign do_push    = push && (cnt != 2'd2);
    assign do_pop     = pop && (cnt != 2'd0);
    assign head_valid = (cnt != 2'd0);
    assign head_data  = mem0;
    assign fill       = cnt;

    // mem0 is always the head; a pop shifts mem1 forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            mem0 <= '0;
            mem1 <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) mem0 <= push_data;
                    else             mem1 <= push_data;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    mem0 <= mem1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        mem0 <= push_data;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/latchn_hs.sv
// Elastic DEPTH-stage pipeline latch with valid/ready handshake and ctr stall/flush control.
// Optional build macro: LATCHN_SKID_BUF_EN adds a 2-entry skid FIFO after the last stage.
module latchn_hs
    import pipe_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 1,
    localparam int CW    = $clog2(DEPTH + 3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ctr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [CW-1:0]    count
);

    ctr_t             ctr_q;
    logic             moving;
    logic             flush;
    logic             accept;
    logic             last_adv;
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] d [DEPTH];

    assign ctr_q  = ctr_t'(ctr);
    assign moving = ctr_moves(ctr_q);
    assign flush  = (ctr_q == CTR_FLUSH);

    // Advance resolves from the output side back, so an empty stage never blocks its predecessor.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = last_adv;
        for (int unsigned k = DEPTH - 1; k > 0; k--) begin
            adv[k-1] = moving && v[k-1] && (!v[k] || adv[k]);
        end
    end

    assign in_ready = !rst && (ctr_q == CTR_RUN) && (!v[0] || adv[0]);
    assign accept   = in_valid && in_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             v_r;
        logic [WIDTH-1:0] d_r;
        logic             load;
        logic [WIDTH-1:0] load_data;

        if (i == 0) begin : g_first
            assign load      = accept;
            assign load_data = data_in;
        end else begin : g_next
            assign load      = adv[i-1];
            assign load_data = d[i-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_r <= 1'b0;
                d_r <= '0;
            end else if (flush) begin
                v_r <= 1'b0;
            end else if (load) begin
                v_r <= 1'b1;
                d_r <= load_data;
            end else if (adv[i]) begin
                v_r <= 1'b0;
            end
        end

        assign v[i] = v_r;
        assign d[i] = d_r;
    end

`ifdef LATCHN_SKID_BUF_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [1:0]       skid_fill;

    assign last_adv  = moving && v[DEPTH-1] && (skid_fill < 2'd2);
    assign out_valid = skid_valid && moving && !rst;
    assign data_out  = skid_data;

    latchn_skid #(.WIDTH(WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (last_adv),
        .push_data (d[DEPTH-1]),
        .pop       (out_valid && out_ready),
        .head_valid(skid_valid),
        .head_data (skid_data),
        .fill      (skid_fill)
    );

    always_comb begin
        count = CW'(skid_fill);
        for (int unsigned k = 0; k < DEPTH; k++) begin
            count = count + CW'(v[k]);
        end
    end
`else
    assign out_valid = v[DEPTH-1] && moving && !rst;
    assign last_adv  = out_valid && out_ready;
    assign data_out  = d[DEPTH-1];

    always_comb begin
        count = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            count = count + CW'(v[k]);
        end
    end
`endif

endmodule

// File: tb/tb_latchn_hs.sv
// Directed self-checking bench for latchn_hs (DEPTH=3); expectations adapt to LATCHN_SKID_BUF_EN.
module tb_latchn_hs;
    import pipe_pkg::*;

    localparam int WIDTH = 16;
    localparam int DEPTH = 3;
`ifdef LATCHN_SKID_BUF_EN
    localparam int LAT = DEPTH + 1;
    localparam int CAP = DEPTH + 2;
`else
    localparam int LAT = DEPTH;
    localparam int CAP = DEPTH;
`endif

    logic                         clk = 1'b0;
    logic                         rst;
    logic [1:0]                   ctr;
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             data_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [WIDTH-1:0]             data_out;
    logic [$clog2(DEPTH+3)-1:0]   count;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [15:0] exp_q [$];
    logic [15:0] bp [4];

    latchn_hs #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .ctr      (ctr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] val);
        bit done = 1'b0;
        in_valid = 1'b1;
        data_in  = val;
        for (int t = 0; t < 20 && !done; t++) begin
            #1;
            if (in_ready) done = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_err++;
            $error("FAIL push observed=timeout expected=accept");
        end
    endtask

    task automatic fill3(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        ctr       = CTR_RUN;
        out_ready = 1'b0;
        push(a); exp_q.push_back(a);
        push(b); exp_q.push_back(b);
        push(c); exp_q.push_back(c);
        repeat (LAT + 2) tick();
    endtask

    task automatic drain(input string tag, input int n);
        int got = 0;
        ctr       = CTR_RUN;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < LAT + n + 4; t++) begin
            #1;
            if (out_valid) begin
                if (exp_q.size() > 0) chk(tag, 32'(data_out), 32'(exp_q.pop_front()));
                got++;
            end
            tick();
        end
        chk({tag, "_n"}, got, n);
        chk({tag, "_count"}, 32'(count), 0);
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        int pre;
        rst = 1'b1; ctr = CTR_RUN; in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
        bp = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
        tick(); tick();
        #1;
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_count", 32'(count), 0);
        chk("rst_data_out", 32'(data_out), 0);
        rst = 1'b0;
        tick();
        chk1("post_rst_in_ready", in_ready, 1'b1);

        // Streaming 0x1..0x8
        out_ready = 1'b1;
        for (int c = 0; c < 8 + LAT + 2; c++) begin
            in_valid = (c < 8);
            data_in  = 16'(c + 1);
            #1;
            if (c < 8) chk1("stream_in_ready", in_ready, 1'b1);
            chk1("stream_out_valid", out_valid, (c >= LAT) && (c < LAT + 8));
            if ((c >= LAT) && (c < LAT + 8)) chk("stream_data", 32'(data_out), c - LAT + 1);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("stream_end_count", 32'(count), 0);

        // Back-pressure fill then drain
        out_ready = 1'b0;
        acc = 0;
        for (int j = 0; j < 6; j++) begin
            in_valid = (acc < 4);
            data_in  = (acc < 4) ? bp[acc] : '0;
            #1;
            chk1("bp_in_ready", in_ready, acc < CAP);
            if (in_valid && (acc < CAP)) begin
                exp_q.push_back(data_in);
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("bp_count", 32'(count), acc);
        out_ready = 1'b1;
        in_valid  = (acc < 4);
        data_in   = (acc < 4) ? bp[acc] : '0;
        #1;
        chk1("bp_rise_in_ready", in_ready, 1'b1);
        chk1("bp_head_valid", out_valid, 1'b1);
        chk("bp_head_data", 32'(data_out), 32'(exp_q.pop_front()));
        pre = acc + ((acc < 4) ? 1 : 0) - 1;
        if (acc < 4) begin
            exp_q.push_back(bp[acc]);
            acc++;
        end
        tick();
        in_valid = 1'b0;
        #1;
        chk("bp_inout_count", 32'(count), pre);
        drain("bp_drain", 3);

        // Bubble collapse
        exp_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1; data_in = 16'h0011;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        in_valid = 1'b1; data_in = 16'h0022;
        tick();
        in_valid = 1'b0;
        repeat (LAT + 2) tick();
        chk("bub_count", 32'(count), 2);
        chk1("bub_out_valid", out_valid, 1'b1);
        chk("bub_head", 32'(data_out), 32'h11);
        out_ready = 1'b1;
        #1;
        chk("bub_first", 32'(data_out), 32'h11);
        tick();
        chk1("bub_second_valid", out_valid, 1'b1);
        chk("bub_second", 32'(data_out), 32'h22);
        tick();
        chk1("bub_empty_valid", out_valid, 1'b0);
        chk("bub_empty_count", 32'(count), 0);

        // Flush
        fill3(16'h0031, 16'h0032, 16'h0033);
        exp_q.delete();
        chk("fl_pre_count", 32'(count), 3);
        ctr = CTR_FLUSH; in_valid = 1'b1; data_in = 16'h0055; out_ready = 1'b1;
        #1;
        chk1("fl_in_ready", in_ready, 1'b0);
        chk1("fl_out_valid", out_valid, 1'b0);
        tick();
        ctr = CTR_RUN; in_valid = 1'b0;
        #1;
        chk("fl_count", 32'(count), 0);
        chk1("fl_after_valid", out_valid, 1'b0);
        for (int t = 0; t < LAT + 3; t++) begin
            #1;
            chk1("fl_no_out", out_valid, 1'b0);
            tick();
        end

        // Hold
        fill3(16'h0041, 16'h0042, 16'h0043);
        ctr = CTR_HOLD; out_ready = 1'b1; in_valid = 1'b1; data_in = 16'h0099;
        for (int t = 0; t < 3; t++) begin
            #1;
            chk1("hold_in_ready", in_ready, 1'b0);
            chk1("hold_out_valid", out_valid, 1'b0);
            chk("hold_count", 32'(count), 3);
            chk("hold_data_out", 32'(data_out), 32'h41);
            tick();
        end
        drain("hold_drain", 3);

        // Mid-operation reset
        fill3(16'h0061, 16'h0062, 16'h0063);
        exp_q.delete();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk1("mrst_out_valid", out_valid, 1'b0);
        chk("mrst_count", 32'(count), 0);
        chk("mrst_data_out", 32'(data_out), 0);
        chk1("mrst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        data_in   = 16'h0077;
        for (int c = 0; c < LAT + 2; c++) begin
            in_valid = (c == 0);
            #1;
            chk1("mrst_lat_valid", out_valid, c == LAT);
            if (c == LAT) chk("mrst_lat_data", 32'(data_out), 32'h77);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
